// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: arbitrates stall/flush requests into per-stage write/flush strobes,
// and keeps saturating stall/flush statistics plus a sticky miss watchdog.
module pipeline_ctrl #(
    parameter int CNT_W        = 16,
    parameter int REDIRECT_CYC = 1,
    parameter int TIMEOUT      = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_hazD,
    input  logic             imiss_req,
    input  logic             imem_ready,
    input  logic             dmiss_req,
    input  logic             dmem_ready,
    input  logic             mispredictE,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic             miss_timeout
);

    localparam logic [1:0]  S_RUN   = 2'd0;
    localparam logic [1:0]  S_IMISS = 2'd1;
    localparam logic [1:0]  S_DMISS = 2'd2;
    localparam logic [1:0]  S_REDIR = 2'd3;
    localparam logic [3:0]  RC      = 4'(REDIRECT_CYC);
    localparam logic [15:0] TO      = 16'(TIMEOUT);

    logic [1:0]       r_state;
    logic [3:0]       r_rcnt;
    logic [15:0]      r_wd;
    logic [CNT_W-1:0] r_stall;
    logic [CNT_W-1:0] r_flush;
    logic             r_timeout;

    logic       w_dstall, w_istall, w_frz, w_mp_go;
    logic       w_pc, w_ifw, w_iff, w_ief, w_exw;
    logic [1:0] w_next;
    logic [3:0] w_rcnt_next;
    logic [15:0] w_wd_next;

    // A ready arriving with its request cancels the stall in the same cycle.
    assign w_dstall = dmiss_req & ~dmem_ready;
    assign w_istall = imiss_req & ~imem_ready;
    assign w_frz    = (r_state == S_DMISS) | w_dstall;
    assign w_mp_go  = ~w_frz & mispredictE;

    always_comb begin
        w_pc        = 1'b1;
        w_ifw       = 1'b1;
        w_iff       = 1'b0;
        w_ief       = 1'b0;
        w_exw       = 1'b1;
        w_next      = r_state;
        w_rcnt_next = r_rcnt;

        if (w_frz) begin
            w_pc  = 1'b0;
            w_ifw = 1'b0;
            w_exw = 1'b0;
        end else if (w_mp_go) begin
            w_iff = 1'b1;
            w_ief = 1'b1;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_istall) begin
                        w_pc  = 1'b0;
                        w_iff = 1'b1;
                    end else if (load_use_hazD) begin
                        w_pc  = 1'b0;
                        w_ifw = 1'b0;
                        w_ief = 1'b1;
                    end
                end
                S_IMISS: begin
                    w_pc  = 1'b0;
                    w_iff = 1'b1;
                end
                S_REDIR: w_iff = 1'b1;
                default: ;
            endcase
        end

        // DMISS only leaves on dmem_ready; mispredict/imiss are re-presented later.
        if (r_state == S_DMISS) begin
            if (dmem_ready) w_next = S_RUN;
        end else if (w_dstall) begin
            w_next      = S_DMISS;
            w_rcnt_next = 4'd0;
        end else if (w_mp_go) begin
            w_next      = S_REDIR;
            w_rcnt_next = RC;
        end else begin
            case (r_state)
                S_RUN:   if (w_istall) w_next = S_IMISS;
                S_IMISS: if (imem_ready) w_next = S_RUN;
                S_REDIR: begin
                    if (r_rcnt <= 4'd1) begin
                        w_next      = S_RUN;
                        w_rcnt_next = 4'd0;
                    end else begin
                        w_rcnt_next = r_rcnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end

        if (!rst_n) begin
            w_pc  = 1'b1;
            w_ifw = 1'b1;
            w_iff = 1'b0;
            w_ief = 1'b0;
            w_exw = 1'b1;
        end
    end

    // Watchdog holds the index of the miss cycle about to run, so it reads TIMEOUT in the TIMEOUT-th cycle.
    assign w_wd_next = (w_next == S_IMISS || w_next == S_DMISS) ?
                       ((r_wd >= TO) ? r_wd : r_wd + 16'd1) : 16'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_RUN;
            r_rcnt    <= 4'd0;
            r_wd      <= 16'd0;
            r_stall   <= '0;
            r_flush   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            r_rcnt  <= w_rcnt_next;
            r_wd    <= w_wd_next;
            if (w_wd_next >= TO) r_timeout <= 1'b1;
            if (!w_pc && r_stall != '1) r_stall <= r_stall + CNT_W'(1);
            if (w_mp_go && r_flush != '1) r_flush <= r_flush + CNT_W'(1);
        end
    end

    assign pc_write     = w_pc;
    assign if_id_write  = w_ifw;
    assign if_id_flush  = w_iff;
    assign id_ex_flush  = w_ief;
    assign ex_mem_write = w_exw;
    assign state        = r_state;
    assign stall_cycles = r_stall;
    assign flush_events = r_flush;
    assign miss_timeout = r_timeout;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios then randomized traffic against a behavioural model.
module tb_pipeline_ctrl;
    localparam int CNT_W = 3;
    localparam int RCYC  = 2;
    localparam int TMO   = 4;
    localparam int SAT   = (1 << CNT_W) - 1;
    localparam int RUN = 0, IMISS = 1, DMISS = 2, REDIR = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_use_hazD = 0, imiss_req = 0, imem_ready = 0;
    logic dmiss_req = 0, dmem_ready = 0, mispredictE = 0;
    logic pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, miss_timeout;
    logic [1:0] state;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    always #5 clk = ~clk;

    pipeline_ctrl #(.CNT_W(CNT_W), .REDIRECT_CYC(RCYC), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .load_use_hazD(load_use_hazD),
        .imiss_req(imiss_req), .imem_ready(imem_ready),
        .dmiss_req(dmiss_req), .dmem_ready(dmem_ready), .mispredictE(mispredictE),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .ex_mem_write(ex_mem_write), .state(state),
        .stall_cycles(stall_cycles), .flush_events(flush_events), .miss_timeout(miss_timeout)
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: the mode the sequencer is in, redirect cycles still owed, and the statistics.
    int m_mode, m_left, m_stall, m_flush, m_miss_run;
    bit m_to;
    bit e_pc, e_ifw, e_iff, e_ief, e_exw, e_flush_cnt;
    int n_mode, n_left;
    logic o_iff, o_ief, o_tmo;

    task automatic model_reset();
        m_mode = RUN; m_left = 0; m_stall = 0; m_flush = 0; m_miss_run = 0; m_to = 0;
    endtask

    task automatic model_eval();
        bit dstall, istall;
        dstall = dmiss_req && !dmem_ready;
        istall = imiss_req && !imem_ready;
        {e_pc, e_ifw, e_iff, e_ief, e_exw} = 5'b11001;
        e_flush_cnt = 0;
        n_mode = m_mode;
        n_left = m_left;
        if (rst_n) begin
            if (m_mode == DMISS || dstall) begin
                {e_pc, e_ifw, e_exw} = 3'b000;
                if (m_mode != DMISS) begin n_mode = DMISS; n_left = 0; end
                else if (dmem_ready) n_mode = RUN;
            end else if (mispredictE) begin
                e_iff = 1; e_ief = 1; e_flush_cnt = 1;
                n_mode = REDIR; n_left = RCYC;
            end else if (m_mode == RUN) begin
                if (istall) begin e_pc = 0; e_iff = 1; n_mode = IMISS; end
                else if (load_use_hazD) begin e_pc = 0; e_ifw = 0; e_ief = 1; end
            end else if (m_mode == IMISS) begin
                e_pc = 0; e_iff = 1;
                if (imem_ready) n_mode = RUN;
            end else begin
                e_iff = 1;
                n_left = m_left - 1;
                if (n_left <= 0) begin n_mode = RUN; n_left = 0; end
            end
        end
    endtask

    task automatic model_commit();
        m_mode = n_mode;
        m_left = n_left;
        if (!e_pc) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
        if (e_flush_cnt) m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
        m_miss_run = (n_mode == IMISS || n_mode == DMISS) ? m_miss_run + 1 : 0;
        if (m_miss_run >= TMO) m_to = 1;
    endtask

    task automatic check_all();
        chk("strobes", {27'd0, pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write},
            {27'd0, e_pc, e_ifw, e_iff, e_ief, e_exw});
        chk("state", {30'd0, state}, m_mode);
        chk("stall_cycles", {29'd0, stall_cycles}, m_stall);
        chk("flush_events", {29'd0, flush_events}, m_flush);
        chk("miss_timeout", {31'd0, miss_timeout}, {31'd0, m_to});
    endtask

    // One clock: drive at negedge, optionally pulse reset, check mid-cycle, advance model at posedge.
    task automatic cyc(input bit rst, input bit lu, input bit im, input bit ir,
                       input bit dm, input bit dr, input bit mp);
        @(negedge clk);
        {load_use_hazD, imiss_req, imem_ready, dmiss_req, dmem_ready, mispredictE} = {lu, im, ir, dm, dr, mp};
        if (rst) begin
            rst_n = 0;
            #1;
            model_reset();
            model_eval();
            check_all();
            rst_n = 1;
        end
        #1;
        model_eval();
        check_all();
        o_iff = if_id_flush;
        o_ief = id_ex_flush;
        o_tmo = miss_timeout;
        @(posedge clk);
        model_commit();
    endtask

    int n_iff;
    logic tmo_h [10];

    initial begin
        model_reset();
        #3;
        model_eval();
        check_all();
        chk("rst_pc_write", {31'd0, pc_write}, 1);
        chk("rst_ex_mem_write", {31'd0, ex_mem_write}, 1);

        // Load-use bubble
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        #1 chk("lu_stall_cycles", {29'd0, stall_cycles}, 1);

        // Mispredict with two held redirect cycles
        cyc(1, 0, 0, 0, 0, 0, 0);
        n_iff = 0;
        cyc(0, 0, 0, 0, 0, 0, 1); n_iff += int'(o_iff);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0); n_iff += int'(o_iff);
        end
        #1;
        chk("mp_iff_cycles", n_iff, 3);
        chk("mp_flush_events", {29'd0, flush_events}, 1);
        chk("mp_state", {30'd0, state}, RUN);

        // Priority: dmiss beats mispredict and load-use
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 0, 1);
        #1;
        chk("prio_state", {30'd0, state}, DMISS);
        chk("prio_flush_events", {29'd0, flush_events}, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 0);
        #1;
        chk("prio_exit_state", {30'd0, state}, RUN);
        chk("prio_stall_cycles", {29'd0, stall_cycles}, 6);

        // Abandon an instruction miss on mispredict
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 1);
        #1;
        chk("abandon_id_ex_flush", {31'd0, o_ief}, 1);
        chk("abandon_state", {30'd0, state}, REDIR);

        // Watchdog and counter saturation
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0, 1, 0, 0);
            tmo_h[i] = o_tmo;
        end
        chk("wd_before", {31'd0, tmo_h[3]}, 0);
        chk("wd_rise", {31'd0, tmo_h[4]}, 1);
        cyc(0, 0, 0, 0, 0, 1, 0);
        #1;
        chk("wd_sticky", {31'd0, miss_timeout}, 1);
        chk("wd_exit_state", {30'd0, state}, RUN);
        chk("stall_saturate", {29'd0, stall_cycles}, SAT);

        // Async reset mid-DMISS with dmiss_req still asserted
        cyc(1, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_state", {30'd0, state}, RUN);
        chk("arst_pc_write", {31'd0, pc_write}, 1);
        chk("arst_ex_mem_write", {31'd0, ex_mem_write}, 1);
        chk("arst_stall_cycles", {29'd0, stall_cycles}, 0);
        chk("arst_miss_timeout", {31'd0, miss_timeout}, 0);
        model_reset();

        // Randomized traffic with occasional reset pulses
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom_range(0, 49) == 0) || (i == 0),
                $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 6) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
